reg_cycle_term: RTL and testbench



---
 rtl/reg_term_pkg.sv | 31 +++
 rtl/term_wait_counter.sv | 40 ++++
 rtl/reg_cycle_term.sv | 172 +++++++++++++++++
 tb/tb_reg_cycle_term.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_term_pkg.sv
// -----------------------------------------------------------------------------
// reg_term_pkg
// Shared definitions for the SDMAC bus-cycle terminator:
//   - term_state_t   : terminator FSM states
//   - DEF_CNTW       : default width of the wait-state / timeout counters
//   - lowest_set_idx : index of the lowest set bit of a select vector
// -----------------------------------------------------------------------------
package reg_term_pkg;

   localparam int DEF_CNTW = 4;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      COUNT    = 3'd1,
      WAIT_EXT = 3'd2,
      TERM     = 3'd3,
      ERR      = 3'd4
   } term_state_t;

   // Lowest set bit wins when several selects are active at once. Callers
   // zero-extend their select vector to 32 bits. Returns 0 for an empty vector.
   function automatic logic [4:0] lowest_set_idx(input logic [31:0] i_vec);
      logic [4:0] idx;
      idx = '0;
      for (int i = 31; i >= 0; i--) begin
         if (i_vec[i]) idx = 5'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/term_wait_counter.sv
// -----------------------------------------------------------------------------
// term_wait_counter
// Loadable down-counter with a zero flag. Used for the per-cycle wait-state
// count. Decrementing stops at zero.
// Ports:
//   i_clk      clock (rising edge)
//   i_rst      synchronous active-high reset, clears the count
//   i_load     load i_load_val (has priority over i_dec)
//   i_load_val value to load
//   i_dec      decrement by one when non-zero
//   o_zero     count is zero
// -----------------------------------------------------------------------------
module term_wait_counter
   import reg_term_pkg::*;
#(
   parameter int CNTW = DEF_CNTW
)(
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_load,
   input  logic [CNTW-1:0] i_load_val,
   input  logic            i_dec,
   output logic            o_zero
);

   logic [CNTW-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CNTW'(1);
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/reg_cycle_term.sv
// -----------------------------------------------------------------------------
// reg_cycle_term
// Multi-channel bus-cycle terminator for SDMAC register/peripheral accesses.
// A cycle is accepted on AS_ low with a non-zero SEL; the lowest selected
// channel is latched, its wait states are counted, an optional external-ready
// wait with timeout follows, and the cycle ends with DSK_ (normal) or
// BERR_ (timeout), held until AS_ is released.
// Ports:
//   nCPUCLK  system clock, rising edge
//   RST      synchronous active-high reset
//   AS_      CPU address strobe, active low
//   SEL      per-channel decoded selects, active high
//   EXT_RDY  per-channel external ready, active high
//   DSK_     registered data-strobe acknowledge, active low
//   BERR_    registered bus error, active low
//   BUSY     high while a cycle is owned (state != IDLE), registered
//   ACT_CH   latched channel index, holds its value in IDLE
// -----------------------------------------------------------------------------
module reg_cycle_term
   import reg_term_pkg::*;
#(
   parameter int                   NCH      = 4,
   parameter int                   CNTW     = DEF_CNTW,
   parameter logic [NCH*CNTW-1:0]  WAIT_CFG = {NCH{CNTW'(4)}},
   parameter logic [NCH-1:0]       EXT_MASK = '0,
   parameter int                   TIMEOUT  = 15
)(
   input  logic                     nCPUCLK,
   input  logic                     RST,
   input  logic                     AS_,
   input  logic [NCH-1:0]           SEL,
   input  logic [NCH-1:0]           EXT_RDY,
   output logic                     DSK_,
   output logic                     BERR_,
   output logic                     BUSY,
   output logic [$clog2(NCH)-1:0]   ACT_CH
);

   localparam int              CHW      = $clog2(NCH);
   localparam logic [CNTW-1:0] TMO_LAST = CNTW'(TIMEOUT - 1);

   if (NCH < 2 || NCH > 32) begin : g_bad_nch
      $error("reg_cycle_term: NCH must be in 2..32");
   end
   if (TIMEOUT < 1 || TIMEOUT > (2**CNTW - 1)) begin : g_bad_timeout
      $error("reg_cycle_term: TIMEOUT must be in 1..2**CNTW-1");
   end

   term_state_t     r_state;
   term_state_t     w_state_nxt;
   logic [CHW-1:0]  r_ch;
   logic [CHW-1:0]  w_sel_ch;
   logic [CNTW-1:0] r_tcnt;
   logic [CNTW-1:0] w_tcnt_nxt;
   logic [CNTW-1:0] w_load_val;
   logic            w_ch_load;
   logic            w_wdec;
   logic            w_wzero;
   logic            w_ext_en;
   logic            w_ext_rdy;
   logic            r_dsk_n;
   logic            r_berr_n;
   logic            r_busy;
   logic            r_armed;
   logic            w_dsk_n_nxt;
   logic            w_berr_n_nxt;

   assign w_sel_ch  = CHW'(lowest_set_idx(32'(SEL)));
   assign w_ext_en  = EXT_MASK[r_ch];
   assign w_ext_rdy = EXT_RDY[r_ch];

   // Wait-state count of the channel being accepted this edge
   always_comb begin
      w_load_val = '0;
      for (int i = 0; i < NCH; i++) begin
         if (w_sel_ch == CHW'(i)) w_load_val = WAIT_CFG[i*CNTW +: CNTW];
      end
   end

   term_wait_counter #(
      .CNTW (CNTW)
   ) u_wcnt (
      .i_clk      (nCPUCLK),
      .i_rst      (RST),
      .i_load     (w_ch_load),
      .i_load_val (w_load_val),
      .i_dec      (w_wdec),
      .o_zero     (w_wzero)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_tcnt_nxt   = r_tcnt;
      w_ch_load    = 1'b0;
      w_wdec       = 1'b0;
      w_dsk_n_nxt  = 1'b1;
      w_berr_n_nxt = 1'b1;
      case (r_state)
         IDLE: begin
            // r_armed blocks acceptance after reset until AS_ has been seen high,
            // so a strobe still low across reset is not taken as a new cycle.
            if (r_armed && !AS_ && (SEL != '0)) begin
               w_ch_load   = 1'b1;
               w_state_nxt = COUNT;
            end
         end
         COUNT: begin
            if (AS_) begin
               w_state_nxt = IDLE;
            end else if (w_wzero) begin
               if (w_ext_en) begin
                  w_tcnt_nxt  = '0;
                  w_state_nxt = WAIT_EXT;
               end else begin
                  w_state_nxt = TERM;
               end
            end else begin
               w_wdec = 1'b1;
            end
         end
         WAIT_EXT: begin
            // Ready is checked before the timeout so it wins on a tie
            if (AS_) begin
               w_state_nxt = IDLE;
            end else if (w_ext_rdy) begin
               w_state_nxt = TERM;
            end else if (r_tcnt == TMO_LAST) begin
               w_state_nxt = ERR;
            end else begin
               w_tcnt_nxt = r_tcnt + CNTW'(1);
            end
         end
         TERM: begin
            if (AS_) w_state_nxt = IDLE;
            else     w_dsk_n_nxt = 1'b0;
         end
         ERR: begin
            if (AS_) w_state_nxt  = IDLE;
            else     w_berr_n_nxt = 1'b0;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge nCPUCLK) begin
      if (RST) begin
         r_state  <= IDLE;
         r_ch     <= '0;
         r_tcnt   <= '0;
         r_dsk_n  <= 1'b1;
         r_berr_n <= 1'b1;
         r_busy   <= 1'b0;
         r_armed  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_tcnt   <= w_tcnt_nxt;
         r_dsk_n  <= w_dsk_n_nxt;
         r_berr_n <= w_berr_n_nxt;
         r_busy   <= (w_state_nxt != IDLE);
         r_armed  <= r_armed | AS_;
         if (w_ch_load) r_ch <= w_sel_ch;
      end
   end

   assign DSK_   = r_dsk_n;
   assign BERR_  = r_berr_n;
   assign BUSY   = r_busy;
   assign ACT_CH = r_ch;

endmodule

// File: tb/tb_reg_cycle_term.sv
module tb_reg_cycle_term;

   localparam int         NCH  = 4;
   localparam int         CNTW = 4;
   localparam int         TMO  = 15;
   // ch0=4, ch1=2, ch2=0, ch3=3 wait states; ch1 and ch2 wait for EXT_RDY
   localparam logic [15:0] CFG  = {4'd3, 4'd0, 4'd2, 4'd4};
   localparam logic [3:0]  MASK = 4'b0110;

   logic       nCPUCLK = 1'b0;
   logic       RST;
   logic       AS_;
   logic [3:0] SEL;
   logic [3:0] EXT_RDY;
   logic       DSK_;
   logic       BERR_;
   logic       BUSY;
   logic [1:0] ACT_CH;

   int n_checks = 0;
   int n_fail   = 0;

   reg_cycle_term #(
      .NCH      (NCH),
      .CNTW     (CNTW),
      .WAIT_CFG (CFG),
      .EXT_MASK (MASK),
      .TIMEOUT  (TMO)
   ) dut (
      .nCPUCLK (nCPUCLK),
      .RST     (RST),
      .AS_     (AS_),
      .SEL     (SEL),
      .EXT_RDY (EXT_RDY),
      .DSK_    (DSK_),
      .BERR_   (BERR_),
      .BUSY    (BUSY),
      .ACT_CH  (ACT_CH)
   );

   always #5 nCPUCLK = ~nCPUCLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int lowest(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return 0;
   endfunction

   function automatic int cfg_of(input int ch);
      logic [15:0] c;
      c = CFG;
      return int'(c[ch*4 +: 4]);
   endfunction

   // ---------------- behavioural model ----------------
   // A cycle is described by its age in edges since acceptance. Counting
   // ends at age cfg+1; an unmasked channel terminates there, a masked one
   // then needs ready (or errors after TIMEOUT waiting edges). The strobe
   // output goes low from the edge after the outcome is decided.
   logic m_valid = 1'b0;
   logic m_owned = 1'b0;
   logic m_arm   = 1'b0;
   logic m_dsk   = 1'b1;
   logic m_berr  = 1'b1;
   int   m_ch    = 0;
   int   m_age   = 0;
   int   m_outc  = 0;   // 0 none, 1 acknowledge, 2 bus error

   always @(posedge nCPUCLK) begin : model
      logic own, arm, dsk, berr;
      int   ch, age, outc, endc;
      logic [3:0] mk;
      own = m_owned; arm = m_arm; ch = m_ch; age = m_age; outc = m_outc;
      dsk = 1'b1; berr = 1'b1; mk = MASK;
      if (RST) begin
         own = 1'b0; arm = 1'b0; ch = 0; age = 0; outc = 0;
      end else begin
         if (!own) begin
            if (arm && !AS_ && SEL != 4'd0) begin
               own = 1'b1; ch = lowest(SEL); age = 0; outc = 0;
            end
         end else begin
            age  = age + 1;
            endc = cfg_of(ch) + 1;
            if (AS_)               own = 1'b0;
            else if (outc == 1)    dsk = 1'b0;
            else if (outc == 2)    berr = 1'b0;
            else if (!mk[ch]) begin
               if (age == endc) outc = 1;
            end else if (age > endc) begin
               if (EXT_RDY[ch])              outc = 1;
               else if (age - endc == TMO)   outc = 2;
            end
         end
         arm = arm | AS_;
      end
      m_valid <= 1'b1;
      m_owned <= own; m_arm <= arm; m_ch <= ch; m_age <= age; m_outc <= outc;
      m_dsk <= dsk; m_berr <= berr;
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge nCPUCLK) begin
      if (m_valid) begin
         check("dsk",    DSK_,   m_dsk);
         check("berr",   BERR_,  m_berr);
         check("busy",   BUSY,   m_owned);
         check("act_ch", ACT_CH, m_ch);
         check("excl",   DSK_ | BERR_, 1);
      end
   end

   task automatic rand_txn();
      int hold, rdy_at, rst_at, gap;
      logic [3:0] s;
      s      = 4'($urandom_range(0, 15));
      hold   = $urandom_range(1, 28);
      rdy_at = $urandom_range(0, 30);
      rst_at = ($urandom_range(0, 19) == 0) ? $urandom_range(0, hold - 1) : -1;
      for (int k = 0; k < hold; k++) begin
         AS_     = 1'b0;
         SEL     = (k == 0 || $urandom_range(0, 3) != 0) ? s : 4'($urandom);
         EXT_RDY = (k >= rdy_at) ? 4'hF : 4'($urandom) & ~s;
         RST     = (k == rst_at);
         @(negedge nCPUCLK);
      end
      RST = 1'b0; AS_ = 1'b1; EXT_RDY = 4'h0;
      gap = $urandom_range(1, 3);
      repeat (gap) @(negedge nCPUCLK);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1; AS_ = 1'b1; SEL = 4'h0; EXT_RDY = 4'h0;
      repeat (2) @(negedge nCPUCLK);
      check("rst_dsk",  DSK_,   1);
      check("rst_berr", BERR_,  1);
      check("rst_busy", BUSY,   0);
      check("rst_ch",   ACT_CH, 0);
      RST = 1'b0;
      @(negedge nCPUCLK);

      // channel 0, 4 wait states: acknowledge on edge 6
      AS_ = 1'b0; SEL = 4'b0001;
      for (int k = 0; k < 10; k++) begin
         @(negedge nCPUCLK);
         if (k == 5) begin check("d1_dsk_e5", DSK_, 1); check("d1_busy", BUSY, 1); end
         if (k == 6) begin check("d1_dsk_e6", DSK_, 0); check("d1_model_e6", m_dsk, 0); end
      end
      AS_ = 1'b1;
      @(negedge nCPUCLK);
      check("d1_rel_dsk", DSK_, 1);
      check("d1_rel_busy", BUSY, 0);

      // channel 2, zero wait states, ready arrives in the external wait
      AS_ = 1'b0; SEL = 4'b0100; EXT_RDY = 4'h0;
      for (int k = 0; k < 8; k++) begin
         @(negedge nCPUCLK);
         if (k == 3) EXT_RDY = 4'b0100;
         if (k == 4) check("d2_dsk_e4", DSK_, 1);
         if (k == 5) begin
            check("d2_dsk_e5", DSK_, 0); check("d2_berr", BERR_, 1); check("d2_model", m_dsk, 0);
         end
      end
      AS_ = 1'b1; EXT_RDY = 4'h0;
      @(negedge nCPUCLK);
      check("d2_rel_dsk", DSK_, 1);

      // channel 1, ready never comes: bus error after 15 waiting edges
      AS_ = 1'b0; SEL = 4'b0010;
      for (int k = 0; k < 22; k++) begin
         @(negedge nCPUCLK);
         if (k == 18) check("d3_berr_e18", BERR_, 1);
         if (k == 19) begin
            check("d3_berr_e19", BERR_, 0); check("d3_dsk", DSK_, 1); check("d3_model", m_berr, 0);
         end
      end
      AS_ = 1'b1;
      @(negedge nCPUCLK);
      check("d3_rel_berr", BERR_, 1);
      check("d3_rel_busy", BUSY, 0);

      // two selects: lowest wins; then abort; then unselected strobe
      AS_ = 1'b0; SEL = 4'b0110;
      for (int k = 0; k < 4; k++) begin
         @(negedge nCPUCLK);
         if (k == 0) begin check("d4_ch", ACT_CH, 1); check("d4_busy", BUSY, 1); end
      end
      AS_ = 1'b1;
      @(negedge nCPUCLK);
      check("d4_abort_busy", BUSY, 0);
      AS_ = 1'b0; SEL = 4'h0;
      repeat (5) begin
         @(negedge nCPUCLK);
         check("d4_nosel_busy", BUSY, 0);
         check("d4_nosel_dsk", DSK_, 1);
      end

      // abort in COUNT, immediate new cycle on channel 3, then reset in TERM
      AS_ = 1'b1; @(negedge nCPUCLK);
      AS_ = 1'b0; SEL = 4'b0001;
      @(negedge nCPUCLK);
      @(negedge nCPUCLK);
      AS_ = 1'b1;
      @(negedge nCPUCLK);
      check("d5_abort_busy", BUSY, 0);
      check("d5_abort_dsk", DSK_, 1);
      AS_ = 1'b0; SEL = 4'b1000;
      for (int k = 0; k < 7; k++) begin
         @(negedge nCPUCLK);
         if (k == 0) check("d5_ch", ACT_CH, 3);
         if (k == 4) check("d5_dsk_e4", DSK_, 1);
         if (k == 5) check("d5_dsk_e5", DSK_, 0);
      end
      RST = 1'b1;
      @(negedge nCPUCLK);
      check("d6_dsk", DSK_, 1);
      check("d6_berr", BERR_, 1);
      check("d6_busy", BUSY, 0);
      check("d6_ch", ACT_CH, 0);
      RST = 1'b0;
      repeat (3) begin
         @(negedge nCPUCLK);
         check("d6_hold_busy", BUSY, 0);
         check("d6_hold_dsk", DSK_, 1);
      end
      AS_ = 1'b1; @(negedge nCPUCLK);
      AS_ = 1'b0; @(negedge nCPUCLK);
      check("d6_fresh_busy", BUSY, 1);
      AS_ = 1'b1;
      repeat (2) @(negedge nCPUCLK);

      // randomized traffic against the model
      for (int t = 0; t < 400; t++) rand_txn();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
